// File: rtl/rr_reg_write_arb_pkg.sv
// rtl/rr_reg_write_arb_pkg.sv - shared macros, FSM encoding and helpers for rr_reg_write_arb
`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef Enable
`define Enable 1'b1
`endif
`ifndef Enable_
`define Enable_ 1'b0
`endif
`ifndef ARB_IDLE
`define ARB_IDLE 1'b0
`endif
`ifndef ARB_HOLD
`define ARB_HOLD 1'b1
`endif

package rr_reg_write_arb_pkg;

  typedef enum logic {
    ST_IDLE = `ARB_IDLE,
    ST_HOLD = `ARB_HOLD
  } arb_state_t;

  localparam int STAT_W = 16;

  // Explicit compare keeps the wrap correct for non-power-of-two NREQ.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_reg_write_arb_pick.sv
// rtl/rr_reg_write_arb_pick.sv - rr_pick: rotating-priority search over req starting at ptr
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic            found
);

  logic [IDXW:0]   sum;
  logic [IDXW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDXW+1)'(k);
      if (sum >= (IDXW+1)'(NREQ)) begin
        sum = sum - (IDXW+1)'(NREQ);
      end
      idx = sum[IDXW-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_reg_write_arb.sv
// rtl/rr_reg_write_arb.sv - round-robin write arbiter in front of one shared register
// Optional per-requester grant counters on grant_cnt when ARB_STATS_EN is defined.
module rr_reg_write_arb
  import rr_reg_write_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = `WIDTH,
  parameter int BURST = 2,
  parameter int IDXW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] din,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic [IDXW-1:0]       owner,
  output logic                  wr_stb
`ifdef ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]    grant_cnt
`endif
);

  localparam int CNTW = $clog2(BURST + 1);

  arb_state_t      state, state_n;
  logic [IDXW-1:0] ptr, ptr_n, owner_n, win_idx;
  logic [CNTW-1:0] cnt, cnt_n;
  logic [NREQ-1:0] pick_gnt;
  logic            pick_found;
  logic            hold_ok;
  logic            load_en;
  logic [WIDTH-1:0] din_sel;

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .found (pick_found)
  );

  assign hold_ok = (state == ST_HOLD) && req[owner] && (cnt < CNTW'(BURST));

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    owner_n = owner;
    gnt     = '0;
    win_idx = '0;
    din_sel = '0;

    if (rst_ != `Enable_) begin
      if (hold_ok) begin
        gnt[owner] = 1'b1;
      end else begin
        gnt = pick_gnt;
      end
    end

    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_idx = IDXW'(i);
        din_sel = din[i*WIDTH +: WIDTH];
      end
    end
    load_en = |gnt;

    // A spent or abandoned burst falls straight into a fresh pick this cycle.
    if (hold_ok) begin
      cnt_n = cnt + CNTW'(1);
    end else if (load_en) begin
      owner_n = win_idx;
      ptr_n   = IDXW'(wrap_inc(int'(win_idx), NREQ));
      cnt_n   = CNTW'(1);
      state_n = (BURST > 1) ? ST_HOLD : ST_IDLE;
    end else begin
      state_n = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (rst_ == `Enable_) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      cnt    <= '0;
      owner  <= '0;
      wr_stb <= 1'b0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      cnt    <= cnt_n;
      owner  <= owner_n;
      wr_stb <= load_en;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (rst_ == `Enable_) begin
      q <= '0;
    end else if (load_en) begin
      q <= din_sel;
    end
  end

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] stat_cnt [NREQ];

  always_ff @(posedge clk or negedge rst_) begin
    if (rst_ == `Enable_) begin
      for (int i = 0; i < NREQ; i++) begin
        stat_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i] && (stat_cnt[i] != {STAT_W{1'b1}})) begin
          stat_cnt[i] <= stat_cnt[i] + STAT_W'(1);
        end
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_cnt[i*16 +: 16] = stat_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_rr_reg_write_arb.sv
// tb/tb_rr_reg_write_arb.sv - scoreboard bench for rr_reg_write_arb, BURST=1 and BURST=2 instances
module tb_rr_reg_write_arb;

  logic        clk = 1'b0;
  logic        rst_;
  logic [3:0]  req1, req2, gnt1, gnt2;
  logic [31:0] din;
  logic [7:0]  q1, q2;
  logic [1:0]  own1, own2;
  logic        stb1, stb2;
`ifdef ARB_STATS_EN
  logic [63:0] gc1, gc2;
`endif

  always #5 clk = ~clk;

  rr_reg_write_arb #(.NREQ(4), .WIDTH(8), .BURST(1)) u_b1 (
    .clk (clk), .rst_ (rst_), .req (req1), .din (din),
    .gnt (gnt1), .q (q1), .owner (own1), .wr_stb (stb1)
`ifdef ARB_STATS_EN
    , .grant_cnt (gc1)
`endif
  );

  rr_reg_write_arb #(.NREQ(4), .WIDTH(8), .BURST(2)) u_b2 (
    .clk (clk), .rst_ (rst_), .req (req2), .din (din),
    .gnt (gnt2), .q (q2), .owner (own2), .wr_stb (stb2)
`ifdef ARB_STATS_EN
    , .grant_cnt (gc2)
`endif
  );

  typedef struct {
    bit         sel;
    int         id;
    logic [7:0] q;
    logic [1:0] owner;
    logic       stb;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   step_id = 0;

  localparam logic [31:0] DIN_DEF = {8'h40, 8'h30, 8'h20, 8'h10};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: drive req, check the combinational grant,
  // queue what the register side must show after the next rising edge.
  task automatic step(input bit sel, input logic [3:0] r, input logic [3:0] eg,
                      input logic [7:0] eq, input logic [1:0] eo, input logic es);
    exp_t e;
    if (sel) req2 = r;
    else     req1 = r;
    #1;
    check_eq($sformatf("gnt_%0d", step_id), sel ? gnt2 : gnt1, eg);
    e.sel = sel; e.id = step_id; e.q = eq; e.owner = eo; e.stb = es;
    sb.push_back(e);
    step_id++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    req1 = '0;
    req2 = '0;
    #2 rst_ = 1'b0;
    @(negedge clk);
    #2 rst_ = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq($sformatf("q_%0d", e.id),     e.sel ? q2 : q1,     e.q);
        check_eq($sformatf("owner_%0d", e.id), e.sel ? own2 : own1, e.owner);
        check_eq($sformatf("stb_%0d", e.id),   e.sel ? stb2 : stb1, e.stb);
      end
    end
  end

  initial begin : stim
    logic [3:0] g2 [5];
    logic [7:0] qv2 [5];
    logic [1:0] ov2 [5];

    rst_ = 1'b0;
    req1 = '0;
    req2 = 4'hF;
    din  = DIN_DEF;
    #2;
    check_eq("rst_gnt_b2", gnt2, 4'h0);
    check_eq("rst_q_b2", q2, 8'h00);
    check_eq("rst_owner_b2", own2, 2'd0);
    check_eq("rst_stb_b2", stb2, 1'b0);
    req2 = '0;
    @(negedge clk);
    #2 rst_ = 1'b1;

    // Reset mid-burst, then first grant must restart at requester 0.
    step(1, 4'hF, 4'b0001, 8'h10, 2'd0, 1'b1);
    step(1, 4'hF, 4'b0001, 8'h10, 2'd0, 1'b1);
    step(1, 4'hF, 4'b0010, 8'h20, 2'd1, 1'b1);
    #2 rst_ = 1'b0;
    #1;
    check_eq("midrst_gnt", gnt2, 4'h0);
    check_eq("midrst_q", q2, 8'h00);
    check_eq("midrst_owner", own2, 2'd0);
    check_eq("midrst_stb", stb2, 1'b0);
    @(posedge clk);
    #1;
    check_eq("midrst_gnt_edge", gnt2, 4'h0);
    check_eq("midrst_q_edge", q2, 8'h00);
    @(negedge clk);
    #2 rst_ = 1'b1;
    step(1, 4'hF, 4'b0001, 8'h10, 2'd0, 1'b1);
    step(1, 4'hF, 4'b0001, 8'h10, 2'd0, 1'b1);
    step(1, 4'hF, 4'b0010, 8'h20, 2'd1, 1'b1);

    // Pure round-robin with all requesters active.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      logic [3:0] eg;
      logic [7:0] eq;
      eg = 4'b0001 << (k % 4);
      eq = 8'(16 * ((k % 4) + 1));
      step(0, 4'hF, eg, eq, 2'(k % 4), 1'b1);
    end
    req1 = '0;

    // Bursts of two alternating between requesters 1 and 2.
    do_reset();
    g2  = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0010};
    qv2 = '{8'h20, 8'h20, 8'h30, 8'h30, 8'h20};
    ov2 = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd1};
    for (int k = 0; k < 5; k++) begin
      step(1, 4'b0110, g2[k], qv2[k], ov2[k], 1'b1);
    end

    // Owner drops mid-burst: hand-off with no idle cycle.
    do_reset();
    step(1, 4'b0010, 4'b0010, 8'h20, 2'd1, 1'b1);
    step(1, 4'b0100, 4'b0100, 8'h30, 2'd2, 1'b1);

    // Idle: q and owner hold, ungranted din changes ignored.
    din[7:0]   = 8'hAA;
    din[23:16] = 8'hBB;
    step(1, 4'b0000, 4'b0000, 8'h30, 2'd2, 1'b0);
    step(1, 4'b0000, 4'b0000, 8'h30, 2'd2, 1'b0);
    step(1, 4'b0000, 4'b0000, 8'h30, 2'd2, 1'b0);
    din = DIN_DEF;
    din[7:0] = 8'h5A;
    step(1, 4'b1000, 4'b1000, 8'h40, 2'd3, 1'b1);
    step(1, 4'b0000, 4'b0000, 8'h40, 2'd3, 1'b0);
    din = DIN_DEF;

    // Lone requester re-wins after its burst is spent.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1, 4'b0010, 4'b0010, 8'h20, 2'd1, 1'b1);
    end
    req2 = '0;

`ifdef ARB_STATS_EN
    do_reset();
    for (int k = 0; k < 8; k++) begin
      logic [3:0] eg;
      logic [7:0] eq;
      eg = 4'b0001 << (k % 4);
      eq = 8'(16 * ((k % 4) + 1));
      step(0, 4'hF, eg, eq, 2'(k % 4), 1'b1);
    end
    req1 = '0;
    #2;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("stat_b1_%0d", i), gc1[i*16 +: 16], 16'd2);
      check_eq($sformatf("stat_b2_%0d", i), gc2[i*16 +: 16], 16'd0);
    end
    req1 = 4'b0001;
    repeat (70000) @(posedge clk);
    #1;
    check_eq("stat_sat_0", gc1[15:0], 16'hFFFF);
    check_eq("stat_hold_1", gc1[31:16], 16'd2);
    req1 = '0;
`endif

    @(posedge clk);
    #2;
    check_eq("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_reg_write_arb.md
Name: rr_reg_write_arb

Overview:
- Round-robin arbiter and sequencer that shares one enable-gated `WIDTH-bit register between NREQ requesters.
- Each cycle it picks at most one requester and drives the register's load enable.
- It captures the winner's data and reports ownership.
- It can hold the grant for a bounded burst of consecutive writes.
- Sits in front of the shared state registers in the datapath, replacing ad-hoc enable muxing.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, `WIDTH, data width of the shared register.
- BURST, 2, max consecutive grants one requester may hold (1 = pure round-robin).
- IDXW, $clog2(NREQ), width of owner index.

Ports:
- clk  input  1  rising-edge clock.
- rst_  input  1  asynchronous active-low reset (asserted when rst_ == `Enable_).
- req  input  NREQ  per-requester write request, level, bit i = requester i.
- din  input  NREQ*WIDTH  flattened write data, slice i = din[i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot combinational grant for the current cycle, all-zero if no winner.
- q  output  WIDTH  shared register value.
- owner  output  IDXW  index of the last requester written, registered.
- wr_stb  output  1  registered one-cycle pulse after each write.
- grant_cnt  output  NREQ*16  per-requester grant counters, present only with ARB_STATS_EN.

Behaviour:
- Reset (rst_ low, async) forces the following:
  - q=0, owner=0, wr_stb=0, ptr=0, cnt=0, state=IDLE.
  - gnt forced to 0 for the whole time rst_ is low.
  - Reset mid-burst abandons the burst; there is no write on the edge where rst_ rises.
- State is held in ptr (IDXW, next starting priority), cnt (burst count) and a two-state FSM (IDLE, HOLD).
- RR pick: the first i with req[i] high, scanning ptr, ptr+1, ... with wrap modulo NREQ. There is no winner if req == 0.
- IDLE:
  - gnt = one-hot RR pick.
  - On the edge with winner w: q<=din slice w, owner<=w, wr_stb<=1, ptr<=(w+1) mod NREQ, cnt<=1.
  - Go to HOLD if BURST>1, else stay in IDLE.
- HOLD:
  - If req[owner]==1 and cnt<BURST: gnt = one-hot owner; on the edge q<=din slice owner, wr_stb<=1, cnt<=cnt+1.
  - Otherwise (owner dropped or burst exhausted): behave exactly as IDLE in the same cycle, with no dead cycle.
    - RR pick from ptr; this may re-select the owner if it is the only requester, starting a new burst with cnt=1.
  - If no winner: go to IDLE.
- No winner: gnt=0, q and owner hold, wr_stb<=0.
- The write-enable-to-q latency is one edge; wr_stb rises on the same edge q updates and lasts exactly one cycle per write.
- Data is sampled only on the granted edge; din changes on non-granted slices have no effect.
- ptr wraps from NREQ-1 to 0; if NREQ is not a power of two, the wrap uses an explicit compare.
- Multiple requests in one cycle produce exactly one grant; gnt is always one-hot or zero.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Adds one 16-bit counter per requester, incremented on every edge at which that requester is granted. Counters saturate at 16'hFFFF.
  - Counters reset to 0 asynchronously with rst_.
  - Exposed on grant_cnt.
- Undefined: no counters and no grant_cnt port; arbitration behaviour is identical.

Decomposition:
- Shared header define.h holds `WIDTH, `Enable, `Enable_, and the new state encodings `ARB_IDLE=1'b0 and `ARB_HOLD=1'b1.
- One sub-module, rr_pick: combinational masked priority search.
  - Inputs: req and ptr.
  - Outputs: one-hot grant and a found flag.
  - Reused by later arbiters.
- The shared register stays inside this block as an enable-gated, async-reset flop.

Test Plan (NREQ=4, WIDTH=8; din slice i = 8'h10*(i+1) unless stated):
- Reset: drive req=4'hF, then pulse rst_ low mid-burst -> gnt=0 while low; q=0, owner=0, wr_stb=0 immediately; first grant after release is requester 0.
- BURST=1, req=4'hF held -> gnt 0001, 0010, 0100, 1000, 0001 on successive cycles; q 10,20,30,40,10; wr_stb high every cycle.
- BURST=2, req=4'b0110 held -> gnt 0010, 0010, 0100, 0100, 0010; owner 1,1,2,2,1.
- BURST=2: req1 alone for 1 cycle, then req1 drops while req2 rises -> gnt 0010 then 0100 with no gap; q=20 then 30.
- req=0 for 3 cycles after writes -> gnt=0, q holds its last value, wr_stb=0; next req=4'b1000 -> gnt 1000 in the same cycle, q=40 on the following edge.
- ARB_STATS_EN, BURST=1, req=4'hF for 8 cycles -> grant_cnt each = 2; with requester 0 alone for 70000 cycles -> its count saturates at 16'hFFFF.
